// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: issues one memory request per op,
// writes load data back to the register file, and aborts on a 16-cycle ack timeout.
module load_store_unit (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        isLoad_i,
  input  logic [4:0]  wbAddress_i,
  input  logic [15:0] pOperand_i,
  input  logic [15:0] sOperand_i,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        memReq_o,
  output logic        memWe_o,
  output logic [15:0] memAddr_o,
  output logic [15:0] memWData_o,
  input  logic        memAck_i,
  input  logic [15:0] memRData_i,
  output logic        wbEnable_o,
  output logic [4:0]  wbAddress_o,
  output logic [15:0] wbData_o,
  output logic        error_o
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 5;
  localparam int unsigned TW = 4;
  localparam logic [TW-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, WB} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          is_load_q, is_load_d;
  logic [RW-1:0] wb_addr_lat_q, wb_addr_lat_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          wb_en_q, wb_en_d;
  logic [RW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          error_q, error_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    is_load_d     = is_load_q;
    wb_addr_lat_d = wb_addr_lat_q;
    overrun_d     = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wb_en_d       = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    error_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          is_load_d     = isLoad_i;
          wb_addr_lat_d = wbAddress_i;
          mem_req_d     = 1'b1;
          mem_we_d      = !isLoad_i;
          mem_addr_d    = pOperand_i;
          mem_wdata_d   = sOperand_i;
          tmo_d         = '0;
          state_d       = REQ;
        end
      end
      REQ: begin
        overrun_d = enable_i;
        // An ack in the final timeout cycle still wins over the timeout
        if (memAck_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (is_load_q) begin
            wb_data_d = memRData_i;
            wb_addr_d = wb_addr_lat_q;
            wb_en_d   = 1'b1;
            state_d   = WB;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_MAX) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          error_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WB: begin
        overrun_d = enable_i;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      is_load_q     <= 1'b0;
      wb_addr_lat_q <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      is_load_q     <= is_load_d;
      wb_addr_lat_q <= wb_addr_lat_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      error_q       <= error_d;
    end
  end

  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
  assign memReq_o    = mem_req_q;
  assign memWe_o     = mem_we_q;
  assign memAddr_o   = mem_addr_q;
  assign memWData_o  = mem_wdata_q;
  assign wbEnable_o  = wb_en_q;
  assign wbAddress_o = wb_addr_q;
  assign wbData_o    = wb_data_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; each task owns one scenario.
module tb_load_store_unit;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        isLoad_i;
  logic [4:0]  wbAddress_i;
  logic [15:0] pOperand_i;
  logic [15:0] sOperand_i;
  logic        busy_o;
  logic        overrun_o;
  logic        memReq_o;
  logic        memWe_o;
  logic [15:0] memAddr_o;
  logic [15:0] memWData_o;
  logic        memAck_i;
  logic [15:0] memRData_i;
  logic        wbEnable_o;
  logic [4:0]  wbAddress_o;
  logic [15:0] wbData_o;
  logic        error_o;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .isLoad_i    (isLoad_i),
    .wbAddress_i (wbAddress_i),
    .pOperand_i  (pOperand_i),
    .sOperand_i  (sOperand_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .memReq_o    (memReq_o),
    .memWe_o     (memWe_o),
    .memAddr_o   (memAddr_o),
    .memWData_o  (memWData_o),
    .memAck_i    (memAck_i),
    .memRData_i  (memRData_i),
    .wbEnable_o  (wbEnable_o),
    .wbAddress_o (wbAddress_o),
    .wbData_o    (wbData_o),
    .error_o     (error_o)
  );

  always #5 clock_i = ~clock_i;

  // Advance one edge; outputs are then sampled and inputs driven 1ns later
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [4:0] wa, input logic [15:0] pa, input logic [15:0] sd);
    enable_i    = 1'b1;
    isLoad_i    = ld;
    wbAddress_i = wa;
    pOperand_i  = pa;
    sOperand_i  = sd;
    step();
    enable_i    = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; enable_i = 1'b0; isLoad_i = 1'b0; wbAddress_i = '0;
    pOperand_i = '0; sOperand_i = '0; memAck_i = 1'b0; memRData_i = '0;
    step(); step();
    reset_i = 1'b0;
    n_cmp++;
    if ({busy_o, overrun_o, memReq_o, memWe_o, wbEnable_o, error_o} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 000000", {busy_o, overrun_o, memReq_o, memWe_o, wbEnable_o, error_o});
    end
    n_cmp++;
    if ({memAddr_o, memWData_o, wbData_o, wbAddress_o} !== 53'h0) begin
      n_err++; $display("FAIL reset_data got %h %h %h %h want all zero", memAddr_o, memWData_o, wbData_o, wbAddress_o);
    end
  endtask

  task automatic test_load_immediate();
    issue(1'b1, 5'd7, 16'h0040, 16'h5555);
    n_cmp++;
    if ({busy_o, memReq_o, memWe_o, memAddr_o} !== {3'b110, 16'h0040}) begin
      n_err++; $display("FAIL load_req got busy=%b req=%b we=%b addr=%h want 1 1 0 0040", busy_o, memReq_o, memWe_o, memAddr_o);
    end
    memAck_i = 1'b1; memRData_i = 16'hBEEF;
    step();
    memAck_i = 1'b0; memRData_i = 16'h0000;
    n_cmp++;
    if ({busy_o, memReq_o, wbEnable_o, wbAddress_o, wbData_o} !== {3'b101, 5'd7, 16'hBEEF}) begin
      n_err++; $display("FAIL load_wb got busy=%b req=%b wben=%b wba=%0d wbd=%h want 1 0 1 7 beef", busy_o, memReq_o, wbEnable_o, wbAddress_o, wbData_o);
    end
    step();
    n_cmp++;
    if ({busy_o, wbEnable_o, wbAddress_o, wbData_o} !== {2'b00, 5'd7, 16'hBEEF}) begin
      n_err++; $display("FAIL load_done got busy=%b wben=%b wba=%0d wbd=%h want 0 0 7 beef", busy_o, wbEnable_o, wbAddress_o, wbData_o);
    end
  endtask

  task automatic test_store_delay();
    issue(1'b0, 5'd2, 16'h0100, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_o, memReq_o, memWe_o, wbEnable_o, memAddr_o, memWData_o} !== {4'b1110, 16'h0100, 16'h1234}) begin
        n_err++; $display("FAIL store_hold[%0d] got busy=%b req=%b we=%b wben=%b addr=%h wd=%h want 1 1 1 0 0100 1234",
                          i, busy_o, memReq_o, memWe_o, wbEnable_o, memAddr_o, memWData_o);
      end
      if (i == 2) memAck_i = 1'b1;
      step();
    end
    memAck_i = 1'b0;
    n_cmp++;
    if ({busy_o, memReq_o, memWe_o, wbEnable_o, wbData_o} !== {4'b0000, 16'hBEEF}) begin
      n_err++; $display("FAIL store_done got busy=%b req=%b we=%b wben=%b wbd=%h want 0 0 0 0 beef", busy_o, memReq_o, memWe_o, wbEnable_o, wbData_o);
    end
  endtask

  task automatic test_timeout();
    int bad;
    issue(1'b1, 5'd3, 16'h0200, 16'h0000);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if ({busy_o, memReq_o, error_o, wbEnable_o} !== 4'b1100) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL timeout_req_cycles got %0d bad of 16 want 0", bad);
    end
    n_cmp++;
    if ({error_o, busy_o, memReq_o, memWe_o, wbEnable_o} !== 5'b10000) begin
      n_err++; $display("FAIL timeout_err got err=%b busy=%b req=%b we=%b wben=%b want 1 0 0 0 0", error_o, busy_o, memReq_o, memWe_o, wbEnable_o);
    end
    step();
    n_cmp++;
    if ({error_o, wbEnable_o, wbData_o} !== {2'b00, 16'hBEEF}) begin
      n_err++; $display("FAIL timeout_after got err=%b wben=%b wbd=%h want 0 0 beef", error_o, wbEnable_o, wbData_o);
    end
    // Same op, but the ack lands in the 16th request cycle
    issue(1'b1, 5'd4, 16'h0208, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin memAck_i = 1'b1; memRData_i = 16'hCAFE; end
      step();
    end
    memAck_i = 1'b0; memRData_i = 16'h0000;
    n_cmp++;
    if ({error_o, memReq_o, wbEnable_o, wbAddress_o, wbData_o} !== {3'b001, 5'd4, 16'hCAFE}) begin
      n_err++; $display("FAIL timeout_late_ack got err=%b req=%b wben=%b wba=%0d wbd=%h want 0 0 1 4 cafe", error_o, memReq_o, wbEnable_o, wbAddress_o, wbData_o);
    end
    step();
    n_cmp++;
    if ({error_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL timeout_late_done got err=%b busy=%b want 0 0", error_o, busy_o);
    end
  endtask

  task automatic test_overrun();
    issue(1'b1, 5'd9, 16'h0300, 16'h0000);
    issue(1'b0, 5'd1, 16'hFFFF, 16'h9999);
    n_cmp++;
    if ({overrun_o, memReq_o, memWe_o, memAddr_o, memWData_o} !== {3'b110, 16'h0300, 16'h0000}) begin
      n_err++; $display("FAIL overrun_req got ovr=%b req=%b we=%b addr=%h wd=%h want 1 1 0 0300 0000", overrun_o, memReq_o, memWe_o, memAddr_o, memWData_o);
    end
    memAck_i = 1'b1; memRData_i = 16'h1111;
    step();
    memAck_i = 1'b0; memRData_i = 16'h0000;
    n_cmp++;
    if ({overrun_o, wbEnable_o, wbAddress_o, wbData_o} !== {2'b01, 5'd9, 16'h1111}) begin
      n_err++; $display("FAIL overrun_wb got ovr=%b wben=%b wba=%0d wbd=%h want 0 1 9 1111", overrun_o, wbEnable_o, wbAddress_o, wbData_o);
    end
    issue(1'b1, 5'd1, 16'hEEEE, 16'h0000);
    n_cmp++;
    if ({overrun_o, busy_o, memReq_o, wbEnable_o} !== 4'b1000) begin
      n_err++; $display("FAIL overrun_in_wb got ovr=%b busy=%b req=%b wben=%b want 1 0 0 0", overrun_o, busy_o, memReq_o, wbEnable_o);
    end
    step();
    n_cmp++;
    if ({overrun_o, busy_o, memReq_o, wbAddress_o, wbData_o} !== {3'b000, 5'd9, 16'h1111}) begin
      n_err++; $display("FAIL overrun_after got ovr=%b busy=%b req=%b wba=%0d wbd=%h want 0 0 0 9 1111", overrun_o, busy_o, memReq_o, wbAddress_o, wbData_o);
    end
  endtask

  task automatic test_back_to_back();
    memAck_i = 1'b1; memRData_i = 16'h7777;
    step();
    n_cmp++;
    if ({busy_o, memReq_o, wbEnable_o, wbData_o} !== {3'b000, 16'h1111}) begin
      n_err++; $display("FAIL idle_ack got busy=%b req=%b wben=%b wbd=%h want 0 0 0 1111", busy_o, memReq_o, wbEnable_o, wbData_o);
    end
    issue(1'b0, 5'd0, 16'h0500, 16'h0A0A);
    step();
    memAck_i = 1'b0;
    n_cmp++;
    if ({busy_o, memReq_o} !== 2'b00) begin
      n_err++; $display("FAIL b2b_store got busy=%b req=%b want 0 0", busy_o, memReq_o);
    end
    memAck_i = 1'b1; memRData_i = 16'h2468;
    issue(1'b1, 5'd5, 16'h0504, 16'h0000);
    n_cmp++;
    if ({busy_o, memReq_o, memWe_o, memAddr_o} !== {3'b110, 16'h0504}) begin
      n_err++; $display("FAIL b2b_accept got busy=%b req=%b we=%b addr=%h want 1 1 0 0504", busy_o, memReq_o, memWe_o, memAddr_o);
    end
    step();
    memAck_i = 1'b0;
    n_cmp++;
    if ({wbEnable_o, wbAddress_o, wbData_o} !== {1'b1, 5'd5, 16'h2468}) begin
      n_err++; $display("FAIL b2b_wb got wben=%b wba=%0d wbd=%h want 1 5 2468", wbEnable_o, wbAddress_o, wbData_o);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    issue(1'b0, 5'd6, 16'h0400, 16'hAAAA);
    n_cmp++;
    if ({memReq_o, memWe_o} !== 2'b11) begin
      n_err++; $display("FAIL rst_pre got req=%b we=%b want 1 1", memReq_o, memWe_o);
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    n_cmp++;
    if ({busy_o, overrun_o, memReq_o, memWe_o, wbEnable_o, error_o, memAddr_o, memWData_o, wbData_o, wbAddress_o} !== 59'h0) begin
      n_err++; $display("FAIL rst_mid got busy=%b req=%b we=%b wben=%b err=%b addr=%h wd=%h wbd=%h wba=%0d want all zero",
                        busy_o, memReq_o, memWe_o, wbEnable_o, error_o, memAddr_o, memWData_o, wbData_o, wbAddress_o);
    end
    issue(1'b1, 5'd31, 16'h0010, 16'h0000);
    memAck_i = 1'b1; memRData_i = 16'h0F0F;
    step();
    memAck_i = 1'b0;
    n_cmp++;
    if ({wbEnable_o, error_o, wbAddress_o, wbData_o} !== {2'b10, 5'd31, 16'h0F0F}) begin
      n_err++; $display("FAIL rst_fresh got wben=%b err=%b wba=%0d wbd=%h want 1 0 31 0f0f", wbEnable_o, error_o, wbAddress_o, wbData_o);
    end
    step();
    n_cmp++;
    if ({busy_o, wbEnable_o} !== 2'b00) begin
      n_err++; $display("FAIL rst_fresh_done got busy=%b wben=%b want 0 0", busy_o, wbEnable_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_immediate();
    test_store_delay();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
